// File: rtl/arbiter_control_pkg.sv
// Shared types and constants for the L1/L2 port arbiter.
// Select encoding: 0 steers the datapath to the D-cache, 1 to the I-cache.
package arbiter_control_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D,
        ARB_RELEASE
    } arb_state_t;

    localparam logic ARB_SEL_D = 1'b0;
    localparam logic ARB_SEL_I = 1'b1;

    // Round-robin pick: a lone requester wins, a tie goes to the side not served last.
    function automatic logic pick_winner(input logic i_req, input logic d_req,
                                         input logic last_grant);
        logic winner;
        if (i_req && d_req) begin
            winner = ~last_grant;
        end else if (i_req) begin
            winner = ARB_SEL_I;
        end else if (d_req) begin
            winner = ARB_SEL_D;
        end else begin
            winner = last_grant;
        end
        return winner;
    endfunction

endpackage

// File: rtl/arbiter_watchdog.sv
// Saturating 16-bit wait counter with a sticky timeout flag for a pending L2 transaction.
// The flag only ever clears through reset; the arbiter keeps waiting after it sets.
module arbiter_watchdog
    import arbiter_control_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic count_en,
    input  logic l2_mem_resp,
    output logic timeout
);

    logic [15:0] count_q, count_d;
    logic        timeout_q, timeout_d;
    logic [16:0] count_next;

    // A response in the cycle that would hit the limit still counts as on time.
    always_comb begin
        count_next = {1'b0, count_q} + 17'd1;
        count_d    = count_q;
        timeout_d  = timeout_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en) begin
            if (!count_next[16]) begin
                count_d = count_next[15:0];
            end
            if (!l2_mem_resp && (count_next >= 17'(TIMEOUT_CYCLES))) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;

endmodule

// File: rtl/arbiter_control.sv
// Sequencing FSM that hands the shared L2 port to the I-cache or D-cache, round-robin on ties.
// Selects are Mealy only in IDLE (zero-cycle grant); everywhere else they follow last_grant_q.
module arbiter_control
    import arbiter_control_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_mem_read,
    input  logic i_mem_write,
    input  logic d_mem_read,
    input  logic d_mem_write,
    input  logic l2_mem_resp,
    output logic readsignalmux_sel,
    output logic writesignalmux_sel,
    output logic memaddressmux_sel,
    output logic memwdatamux_sel,
    output logic memrdatademux_sel,
    output logic memrespmux_sel,
    output logic arb_busy,
    output logic arb_timeout
);

    arb_state_t state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       busy_q, busy_d;
    logic       i_req, d_req, winner, sel;
    logic       wd_clear, wd_count_en;

    assign i_req  = i_mem_read | i_mem_write;
    assign d_req  = d_mem_read | d_mem_write;
    assign winner = pick_winner(i_req, d_req, last_grant_q);

    // While serving, last_grant_q already holds the granted side, so it doubles as the select.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sel          = last_grant_q;
        wd_clear     = 1'b0;
        wd_count_en  = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                sel = winner;
                if (i_req || d_req) begin
                    state_d      = (winner == ARB_SEL_I) ? ARB_SERVE_I : ARB_SERVE_D;
                    last_grant_d = winner;
                    wd_clear     = 1'b1;
                end
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
                wd_count_en = 1'b1;
                if (l2_mem_resp) begin
                    state_d = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= ARB_SEL_I;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
        end
    end

    arbiter_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (wd_clear),
        .count_en   (wd_count_en),
        .l2_mem_resp(l2_mem_resp),
        .timeout    (arb_timeout)
    );

    assign readsignalmux_sel  = sel;
    assign writesignalmux_sel = sel;
    assign memaddressmux_sel  = sel;
    assign memwdatamux_sel    = sel;
    assign memrdatademux_sel  = sel;
    assign memrespmux_sel     = sel;
    assign arb_busy           = busy_q;

endmodule

// File: tb/tb_arbiter_control.sv
// Scoreboard bench for arbiter_control: a transaction-level model predicts each cycle's
// selects/busy/timeout, and a negedge monitor pops and compares them.
module tb_arbiter_control;

    localparam int TIMEOUT = 8;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] I_RD = 4'b1000;
    localparam logic [3:0] D_RD = 4'b0010;
    localparam logic [3:0] D_WR = 4'b0001;
    localparam logic [3:0] BOTH = 4'b1010;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic i_mem_read = 1'b0, i_mem_write = 1'b0;
    logic d_mem_read = 1'b0, d_mem_write = 1'b0;
    logic l2_mem_resp = 1'b0;
    logic readsignalmux_sel, writesignalmux_sel, memaddressmux_sel;
    logic memwdatamux_sel, memrdatademux_sel, memrespmux_sel;
    logic arb_busy, arb_timeout;

    always #5 clk = ~clk;

    arbiter_control #(
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .i_mem_read        (i_mem_read),
        .i_mem_write       (i_mem_write),
        .d_mem_read        (d_mem_read),
        .d_mem_write       (d_mem_write),
        .l2_mem_resp       (l2_mem_resp),
        .readsignalmux_sel (readsignalmux_sel),
        .writesignalmux_sel(writesignalmux_sel),
        .memaddressmux_sel (memaddressmux_sel),
        .memwdatamux_sel   (memwdatamux_sel),
        .memrdatademux_sel (memrdatademux_sel),
        .memrespmux_sel    (memrespmux_sel),
        .arb_busy          (arb_busy),
        .arb_timeout       (arb_timeout)
    );

    typedef struct packed {
        logic sel;
        logic busy;
        logic timeout;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Model: who owns L2 (nobody / a side / cooling down), whose turn it is, how long we waited.
    int   m_phase;
    logic m_owner;
    logic m_last;
    int   m_waited;
    logic m_timed_out;

    task automatic model_reset();
        m_phase     = 0;
        m_owner     = 1'b1;
        m_last      = 1'b1;
        m_waited    = 0;
        m_timed_out = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [3:0] req, input logic resp, input logic rst);
        exp_t e;
        logic iq, dq, win;
        @(posedge clk);
        #1;
        reset_n = ~rst;
        {i_mem_read, i_mem_write, d_mem_read, d_mem_write} = req;
        l2_mem_resp = resp;
        if (rst) model_reset();
        iq  = req[3] | req[2];
        dq  = req[1] | req[0];
        win = (iq && dq) ? ~m_last : (iq ? 1'b1 : (dq ? 1'b0 : m_last));
        e.sel     = (m_phase == 0) ? win : ((m_phase == 1) ? m_owner : m_last);
        e.busy    = (m_phase != 0);
        e.timeout = m_timed_out;
        exp_q.push_back(e);
        if (!rst) begin
            case (m_phase)
                0: if (iq || dq) begin
                    m_phase  = 1;
                    m_owner  = win;
                    m_last   = win;
                    m_waited = 0;
                end
                1: if (resp) begin
                    m_phase = 2;
                end else begin
                    m_waited++;
                    if (m_waited >= TIMEOUT) m_timed_out = 1'b1;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic check_output(input string name, input logic [5:0] act, input logic [5:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s at %0t: actual=%b required=%b", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("sels", {readsignalmux_sel, writesignalmux_sel, memaddressmux_sel,
                                  memwdatamux_sel, memrdatademux_sel, memrespmux_sel}, {6{e.sel}});
            check_output("arb_busy", {5'b0, arb_busy}, {5'b0, e.busy});
            check_output("arb_timeout", {5'b0, arb_timeout}, {5'b0, e.timeout});
        end
    end

    // One transaction: grant cycle in IDLE, lat SERVE cycles ending in resp, one RELEASE.
    task automatic transaction(input logic [3:0] req, input int lat, input logic [3:0] rel_req);
        apply_stimulus(req, 1'b0, 1'b0);
        for (int k = 0; k < lat - 1; k++) apply_stimulus(req, 1'b0, 1'b0);
        apply_stimulus(req, 1'b1, 1'b0);
        apply_stimulus(rel_req, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (3) apply_stimulus(NONE, 1'b0, 1'b1);
        repeat (2) apply_stimulus(NONE, 1'b0, 1'b0);
        // Stray responses while idle must not move anything.
        apply_stimulus(NONE, 1'b1, 1'b0);
        apply_stimulus(NONE, 1'b0, 1'b0);
        // Simultaneous first requests: D wins, then I is granted right after RELEASE.
        transaction(BOTH, 3, I_RD);
        transaction(I_RD, 5, NONE);
        apply_stimulus(NONE, 1'b0, 1'b0);
        // Fairness under continuous contention.
        for (int t = 0; t < 6; t++) transaction(BOTH, int'($urandom_range(4, 1)), BOTH);
        apply_stimulus(NONE, 1'b1, 1'b0);
        // Watchdog: L2 stays silent past the limit, then finally answers.
        transaction(I_RD, TIMEOUT + 4, NONE);
        transaction(D_WR, 2, NONE);
        apply_stimulus(NONE, 1'b0, 1'b0);
        // Reset in the middle of a D transaction, then a fresh D read.
        apply_stimulus(D_RD, 1'b0, 1'b0);
        apply_stimulus(D_RD, 1'b0, 1'b0);
        apply_stimulus(NONE, 1'b0, 1'b1);
        apply_stimulus(NONE, 1'b0, 1'b1);
        transaction(D_RD, 2, NONE);
        // Random traffic, occasional resets.
        for (int n = 0; n < 400; n++) begin
            apply_stimulus(4'($urandom), ($urandom_range(3, 0) == 0), ($urandom_range(199, 0) == 0));
        end
        repeat (2) apply_stimulus(NONE, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
